flash_writer: RTL and testbench

Programs the parallel NOR flash with a 24-bit RGB image stream, one byte per flash address. It is the write-side counterpart of the EPHOTO flash read path: it accepts packed 32-bit words and splits each word into three bytes. It writes the bytes to consecutive addresses from 0 up to FILE_SIZE using the AMD byte-mode program command sequence, so the stored image reads back byte-identical. It sits between the image source (UART/host loader) and the flash pins, and is muxed against the reader by top-level mode select.

---
 rtl/flash_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_flash_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_writer.sv
// flash_writer: programs a parallel NOR flash, one byte per address, from a
// stream of packed 24-bit RGB words using the AMD byte-program sequence.
// Optional build macro FLASH_WRITER_CHIP_ERASE_EN: issue a chip erase after
// the power-up delay, before any word is accepted.
module flash_writer #(
  parameter logic [22:0] FILE_SIZE = 23'h34BC00,
  parameter int unsigned WE_LOW    = 4,
  parameter int unsigned RY_WAIT   = 4,
  parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic [31:0] iDATA,
  input  logic        iDVALID,
  output logic        oREADY,
  input  logic        iRY,
  output logic        oCE_N,
  output logic        oWE_N,
  output logic        oOE_N,
  output logic [22:0] oADDR,
  output logic [7:0]  oDATA,
  output logic        oDONE,
  output logic        oERR
);

  localparam logic [23:0] WE_LAST      = 24'(WE_LOW - 1);
  localparam logic [23:0] RY_WAIT_C    = 24'(RY_WAIT);
  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;
  localparam logic [2:0]  PROG_LAST    = 3'd3;
  localparam logic [2:0]  ERASE_LAST   = 3'd5;

  typedef enum logic [2:0] {
    S_RST_DLY, S_ERASE, S_IDLE, S_PROG, S_BUSY_WAIT, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HOLD} phase_t;

  // Bus address/data for one step of the erase or program command sequence.
  function automatic logic [30:0] f_cmd(input logic erase, input logic [2:0] step,
                                       input logic [22:0] baddr, input logic [7:0] bbyte);
    logic [30:0] v;
    if (erase) begin
      case (step)
        3'd0:    v = {23'h000AAA, 8'hAA};
        3'd1:    v = {23'h000555, 8'h55};
        3'd2:    v = {23'h000AAA, 8'h80};
        3'd3:    v = {23'h000AAA, 8'hAA};
        3'd4:    v = {23'h000555, 8'h55};
        3'd5:    v = {23'h000AAA, 8'h10};
        default: v = {23'h000000, 8'h00};
      endcase
    end else begin
      case (step)
        3'd0:    v = {23'h000AAA, 8'hAA};
        3'd1:    v = {23'h000555, 8'h55};
        3'd2:    v = {23'h000AAA, 8'hA0};
        3'd3:    v = {baddr, bbyte};
        default: v = {23'h000000, 8'h00};
      endcase
    end
    return v;
  endfunction

  state_t      r_state, w_state_nxt;
  phase_t      r_phase, w_phase_nxt;
  logic [23:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_step, w_step_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [22:0] r_addr, w_addr_nxt;
  logic [23:0] r_data, w_data_nxt;
  logic        r_erasing, w_erasing_nxt;
  logic        r_err, w_err_nxt;

  logic        r_ready, r_ce_n, r_we_n, r_oe_n, r_done;
  logic [22:0] r_addr_o;
  logic [7:0]  r_dout;

  logic        w_bus, w_ready_nxt, w_ce_n_nxt, w_we_n_nxt, w_done_nxt;
  logic [2:0]  w_last_step;
  logic [7:0]  w_byte;
  logic [30:0] w_cmd;
  logic [22:0] w_addr_o_nxt;
  logic [7:0]  w_dout_nxt;
  logic        w_unused_data;

  assign w_unused_data = ^iDATA[31:24];
  assign w_last_step   = (r_state == S_ERASE) ? ERASE_LAST : PROG_LAST;

  // Next-state logic: sequencing of states, bus phases, counters and byte index.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_cnt_nxt     = r_cnt;
    w_step_nxt    = r_step;
    w_idx_nxt     = r_idx;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_erasing_nxt = r_erasing;
    w_err_nxt     = r_err;
    case (r_state)
      S_RST_DLY: begin
        if (r_cnt != 24'd1) begin
          w_cnt_nxt = r_cnt + 24'd1;
        end else if (iRY) begin
          w_cnt_nxt   = 24'd0;
          w_step_nxt  = 3'd0;
          w_phase_nxt = PH_SETUP;
`ifdef FLASH_WRITER_CHIP_ERASE_EN
          w_state_nxt   = S_ERASE;
          w_erasing_nxt = 1'b1;
`else
          w_state_nxt   = S_IDLE;
`endif
        end else begin
          w_state_nxt = S_RST_DLY;
        end
      end
      S_IDLE: begin
        if (iDVALID && r_ready) begin
          w_data_nxt  = iDATA[23:0];
          w_idx_nxt   = 2'd0;
          w_step_nxt  = 3'd0;
          w_phase_nxt = PH_SETUP;
          w_cnt_nxt   = 24'd0;
          w_state_nxt = S_PROG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PROG, S_ERASE: begin
        case (r_phase)
          PH_SETUP: begin
            w_phase_nxt = PH_LOW;
            w_cnt_nxt   = 24'd0;
          end
          PH_LOW: begin
            if (r_cnt == WE_LAST) begin
              w_phase_nxt = PH_HOLD;
            end else begin
              w_cnt_nxt = r_cnt + 24'd1;
            end
          end
          PH_HOLD: begin
            if (r_step == w_last_step) begin
              w_state_nxt = S_BUSY_WAIT;
              w_cnt_nxt   = 24'd0;
            end else begin
              w_step_nxt  = r_step + 3'd1;
              w_phase_nxt = PH_SETUP;
            end
          end
          default: w_phase_nxt = PH_SETUP;
        endcase
      end
      S_BUSY_WAIT: begin
        if ((r_cnt >= RY_WAIT_C) && iRY) begin
          w_state_nxt   = r_erasing ? S_IDLE : S_NEXT;
          w_erasing_nxt = 1'b0;
          w_cnt_nxt     = 24'd0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      S_NEXT: begin
        w_addr_nxt = r_addr + 23'd1;
        if ((r_addr + 23'd1) == FILE_SIZE) begin
          w_state_nxt = S_DONE;
        end else if (r_idx < 2'd2) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_step_nxt  = 3'd0;
          w_phase_nxt = PH_SETUP;
          w_state_nxt = S_PROG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_DONE;
    endcase
  end

  // Output decode from the next state so every flash pin comes straight from a flop.
  always_comb begin
    w_bus = (w_state_nxt == S_PROG) || (w_state_nxt == S_ERASE);
    case (w_idx_nxt)
      2'd0:    w_byte = w_data_nxt[7:0];
      2'd1:    w_byte = w_data_nxt[15:8];
      2'd2:    w_byte = w_data_nxt[23:16];
      default: w_byte = 8'h00;
    endcase
    w_cmd        = f_cmd(w_state_nxt == S_ERASE, w_step_nxt, w_addr_nxt, w_byte);
    w_ce_n_nxt   = ~w_bus;
    w_we_n_nxt   = ~(w_bus && (w_phase_nxt == PH_LOW));
    w_addr_o_nxt = w_bus ? w_cmd[30:8] : r_addr_o;
    w_dout_nxt   = w_bus ? w_cmd[7:0] : r_dout;
    w_ready_nxt  = (w_state_nxt == S_IDLE);
    w_done_nxt   = r_done | (w_state_nxt == S_DONE);
  end

  // State, counters and registered outputs; reset releases the strobes at once.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_state   <= S_RST_DLY;
      r_phase   <= PH_SETUP;
      r_cnt     <= 24'd0;
      r_step    <= 3'd0;
      r_idx     <= 2'd0;
      r_addr    <= 23'd0;
      r_data    <= 24'd0;
      r_erasing <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_addr_o  <= 23'd0;
      r_dout    <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step    <= w_step_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_erasing <= w_erasing_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= w_ready_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_oe_n    <= 1'b1;
      r_addr_o  <= w_addr_o_nxt;
      r_dout    <= w_dout_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign oREADY = r_ready;
  assign oCE_N  = r_ce_n;
  assign oWE_N  = r_we_n;
  assign oOE_N  = r_oe_n;
  assign oADDR  = r_addr_o;
  assign oDATA  = r_dout;
  assign oDONE  = r_done;
  assign oERR   = r_err;

endmodule

// File: tb/tb_flash_writer.sv
// Bench for flash_writer: streams words into a small flash model, checks the
// command sequence, bus timing, stored bytes, partial last word, timeout and
// reset during a write pulse.
module tb_flash_writer;

  localparam logic [22:0] FS = 23'd301;
  localparam int NW = 104;

  logic        iCLK = 1'b0;
  logic        iRSTN = 1'b1;
  logic [31:0] iDATA = 32'd0;
  logic        iDVALID = 1'b0;
  logic        iRY = 1'b1;
  logic        oREADY, oCE_N, oWE_N, oOE_N, oDONE, oERR;
  logic [22:0] oADDR;
  logic [7:0]  oDATA;

  always #5 iCLK = ~iCLK;

  flash_writer #(.FILE_SIZE(FS), .WE_LOW(4), .RY_WAIT(4), .TIMEOUT(24'd50)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iDATA(iDATA), .iDVALID(iDVALID), .oREADY(oREADY),
    .iRY(iRY), .oCE_N(oCE_N), .oWE_N(oWE_N), .oOE_N(oOE_N), .oADDR(oADDR),
    .oDATA(oDATA), .oDONE(oDONE), .oERR(oERR)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t        vecs [NW];
  logic [30:0] exp_q [$];
  logic [7:0]  mem [512];
  logic        written [512];

  int n_tests = 0;
  int n_fails = 0;
  logic        prev_we_n, prev_ce_n;
  logic [22:0] prev_addr, cap_addr;
  logic [7:0]  prev_data, cap_data;
  logic [22:0] exp_addr;
  int low_cnt, cmd_pos, n_writes, ry_cnt, oe_bad, stab_bad;
  int tick_no, prog_tick, n_accept, word_ptr;
  bit ry_stuck, stuck_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] vec_byte(input int k, input int b);
    logic [7:0] v;
    case (b)
      0:       v = vecs[k].b0;
      1:       v = vecs[k].b1;
      default: v = vecs[k].b2;
    endcase
    return v;
  endfunction

  task automatic push_word(input int k);
    for (int b = 0; b < 3; b++) begin
      if (exp_addr < FS) exp_q.push_back({exp_addr, vec_byte(k, b)});
      exp_addr = exp_addr + 23'd1;
    end
  endtask

  task automatic process_write(input logic [22:0] a, input logic [7:0] d);
    logic [30:0] e;
    n_writes++;
    case (cmd_pos)
      0: check("cmd1", 32'({a, d}), 32'({23'hAAA, 8'hAA}));
      1: check("cmd2", 32'({a, d}), 32'({23'h555, 8'h55}));
      2: check("cmd3", 32'({a, d}), 32'({23'hAAA, 8'hA0}));
      default: begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL prog_unexpected: got addr %h data %h, expected no write", a, d);
        end else begin
          e = exp_q.pop_front();
          check("prog_byte", 32'({a, d}), 32'(e));
        end
        if (a < 23'd512) begin
          mem[a[8:0]] = d;
          written[a[8:0]] = 1'b1;
        end
        ry_cnt = 10;
        if (stuck_mode) ry_stuck = 1'b1;
        prog_tick = tick_no;
      end
    endcase
    cmd_pos = (cmd_pos + 1) % 4;
  endtask

  task automatic monitor();
    if (oOE_N !== 1'b1) oe_bad++;
    if (prev_we_n && !oWE_N) begin
      low_cnt = 1;
      cap_addr = oADDR;
      cap_data = oDATA;
      if (prev_ce_n !== 1'b0 || prev_addr !== oADDR || prev_data !== oDATA || oCE_N !== 1'b0) stab_bad++;
    end else if (!prev_we_n && !oWE_N) begin
      low_cnt++;
      if (oADDR !== cap_addr || oDATA !== cap_data || oCE_N !== 1'b0) stab_bad++;
    end else if (!prev_we_n && oWE_N) begin
      check("we_low_len", 32'(low_cnt), 32'd4);
      if (oCE_N !== 1'b0 || oADDR !== cap_addr || oDATA !== cap_data) stab_bad++;
      process_write(cap_addr, cap_data);
    end
    prev_we_n = oWE_N;
    prev_ce_n = oCE_N;
    prev_addr = oADDR;
    prev_data = oDATA;
  endtask

  task automatic tick();
    bit acc;
    acc = iDVALID && oREADY && iRSTN;
    @(posedge iCLK);
    @(negedge iCLK);
    tick_no++;
    if (acc) begin
      n_accept++;
      push_word(word_ptr);
      word_ptr++;
      iDATA = vecs[(word_ptr < NW) ? word_ptr : NW - 1].data;
    end
    monitor();
    if (ry_stuck) begin
      iRY = 1'b0;
    end else if (ry_cnt > 0) begin
      iRY = 1'b0;
      ry_cnt--;
    end else begin
      iRY = 1'b1;
    end
  endtask

  task automatic mon_reset();
    prev_we_n = 1'b1; prev_ce_n = 1'b1; prev_addr = 23'd0; prev_data = 8'd0;
    low_cnt = 0; cmd_pos = 0; ry_cnt = 0; ry_stuck = 1'b0; n_writes = 0;
    exp_q.delete(); exp_addr = 23'd0; n_accept = 0; word_ptr = 0;
    iRY = 1'b1; iDVALID = 1'b0; iDATA = vecs[0].data;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(oREADY), 32'd0);
    check({tag, "_ce_n"},  32'(oCE_N),  32'd1);
    check({tag, "_we_n"},  32'(oWE_N),  32'd1);
    check({tag, "_oe_n"},  32'(oOE_N),  32'd1);
    check({tag, "_addr"},  32'(oADDR),  32'd0);
    check({tag, "_data"},  32'(oDATA),  32'd0);
    check({tag, "_done"},  32'(oDONE),  32'd0);
    check({tag, "_err"},   32'(oERR),   32'd0);
  endtask

  task automatic reset_and_wait_ready(input string tag);
    iRSTN = 1'b0;
    mon_reset();
    #2;
    check_reset_values(tag);
    @(negedge iCLK);
    iRSTN = 1'b1;
    tick();
    check({tag, "_rstdly1_ready"}, 32'(oREADY), 32'd0);
    tick();
    check({tag, "_rstdly2_ready"}, 32'(oREADY), 32'd1);
  endtask

  initial begin
    int wr_before, na0, err_tick;
    logic [7:0] eb;

    // Stimulus table: hand-picked words first, then random fill.
    vecs[0] = '{32'hFF332211, 8'h11, 8'h22, 8'h33};
    vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD};
    vecs[3] = '{32'h12FFFFFF, 8'hFF, 8'hFF, 8'hFF};
    for (int k = 4; k < NW; k++) begin
      vecs[k].data = $urandom;
      vecs[k].b0 = vecs[k].data[7:0];
      vecs[k].b1 = vecs[k].data[15:8];
      vecs[k].b2 = vecs[k].data[23:16];
    end
    for (int k = 0; k < 512; k++) begin
      mem[k] = 8'hFF;
      written[k] = 1'b0;
    end
    tick_no = 0; prog_tick = 0; oe_bad = 0; stab_bad = 0; stuck_mode = 1'b0;

    // Power-up reset, then stream 101 words with iDVALID held high.
    #2;
    reset_and_wait_ready("rst1");
    iDVALID = 1'b1;
    for (int c = 0; c < 20000 && !oDONE; c++) tick();
    check("stream_done", 32'(oDONE), 32'd1);
    check("stream_err", 32'(oERR), 32'd0);
    check("done_ready", 32'(oREADY), 32'd0);
    check("done_ce_n", 32'(oCE_N), 32'd1);
    wr_before = n_writes;
    for (int c = 0; c < 50; c++) tick();
    check("no_writes_after_done", 32'(n_writes), 32'(wr_before));
    check("total_writes", 32'(n_writes), 32'd1204);
    check("words_accepted", 32'(n_accept), 32'd101);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("partial_b1_unwritten", 32'(written[301]), 32'd0);
    check("partial_b2_unwritten", 32'(written[302]), 32'd0);
    check("mem0", 32'(mem[0]), 32'h11);
    check("mem1", 32'(mem[1]), 32'h22);
    check("mem2", 32'(mem[2]), 32'h33);
    for (int k = 0; k < 301; k++) begin
      eb = vec_byte(k / 3, k % 3);
      if (mem[k] !== eb || written[k] !== 1'b1) check("mem_content", 32'(mem[k]), 32'(eb));
    end
    check("oe_always_high", 32'(oe_bad), 32'd0);
    check("addr_data_stable", 32'(stab_bad), 32'd0);

    // RY stuck low after the first program command: timeout after 50 cycles.
    reset_and_wait_ready("rst2");
    stuck_mode = 1'b1;
    na0 = n_accept;
    iDVALID = 1'b1;
    for (int c = 0; c < 20 && n_accept == na0; c++) tick();
    iDVALID = 1'b0;
    check("accept_one", 32'(n_accept), 32'(na0 + 1));
    check("accept_to_ce", 32'(oCE_N), 32'd0);
    check("first_cmd_addr", 32'(oADDR), 32'hAAA);
    for (int c = 0; c < 200 && !oERR; c++) tick();
    err_tick = tick_no;
    check("timeout_err", 32'(oERR), 32'd1);
    check("timeout_done", 32'(oDONE), 32'd1);
    check("timeout_latency", 32'(err_tick - prog_tick), 32'd51);
    for (int c = 0; c < 30; c++) tick();
    check("timeout_writes", 32'(n_writes), 32'd4);
    check("timeout_ready", 32'(oREADY), 32'd0);
    stuck_mode = 1'b0;

    // Reset asserted while oWE_N is low.
    reset_and_wait_ready("rst3");
    iDVALID = 1'b1;
    for (int c = 0; c < 30 && oWE_N; c++) tick();
    iDVALID = 1'b0;
    check("we_low_seen", 32'(oWE_N), 32'd0);
    #2;
    iRSTN = 1'b0;
    #1;
    check("midrst_we_n", 32'(oWE_N), 32'd1);
    check("midrst_ce_n", 32'(oCE_N), 32'd1);
    check("midrst_addr", 32'(oADDR), 32'd0);
    check("midrst_ready", 32'(oREADY), 32'd0);
    @(negedge iCLK);
    mon_reset();
    iRSTN = 1'b1;
    tick();
    check("midrst_dly1_ready", 32'(oREADY), 32'd0);
    tick();
    check("midrst_dly2_ready", 32'(oREADY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
